spm_mem: RTL and testbench
==========================

Name: spm_mem

Overview:
- Single-port scratchpad memory (SPM): a word-addressed on-chip RAM, tightly coupled to the CPU.
- Serves synchronous word reads and writes through one address-strobe interface.
- Reads return data one clock after the access is issued.
- Serves as the low-latency local memory for the CPU pipeline (instruction/data scratch space).

Parameters:
- DATA_W, 32, word width in bits (WordDataBus).
- ADDR_W, 12, word-address width in bits (SpmAddrBus); depth = 2**ADDR_W = 4096 words (16 KiB).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_spm_addr  in  ADDR_W  word address.
- if_spm_as_  in  1  address strobe, active-low (ENABLE_=0, DISABLE_=1).
- if_spm_rw  in  1  access direction: READ=1, WRITE=0. Qualified by as_.
- if_spm_wr_data  in  DATA_W  write data.
- if_spm_rd_data  out  DATA_W  registered read data.

Interface (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Storage: array of 2**ADDR_W words of DATA_W bits. The array is not cleared by reset; contents are undefined until written.
- Write:
  - Condition: rising edge with as_=0 and rw=WRITE.
  - Action: mem[addr] <= wr_data.
  - rd_data holds its previous value.
- Read:
  - Condition: rising edge with as_=0 and rw=READ.
  - Action: rd_data <= mem[addr].
  - Latency: exactly 1 cycle; data is valid after the edge that sampled the request and stays stable until the next read edge or reset.
- Idle: as_=1.
  - No write occurs and rd_data holds.
  - rw, addr and wr_data are don't-care and may be X without effect.
- Back-to-back accesses:
  - One access per cycle, no wait states, no busy/ready handshake.
  - A read issued in the cycle after a write to the same address returns the newly written data.
- Address range: the full address range is valid; no wrap or aliasing logic is needed, since the address width equals the depth.
- Reset:
  - rst=1 forces rd_data to 0 immediately (asynchronous) and holds it at 0 while asserted.
  - Any access requested on an edge while rst=1 is ignored (no write, no read).
  - Deassertion takes effect on the next rising edge.
  - Reset mid-operation leaves the array contents unchanged.
- No X propagation from an unselected cycle: X on rw while as_=1 must not corrupt memory or rd_data.
- Implementation: inferable as FPGA block RAM (synchronous read, registered output).

Decomposition:
- Shared package/header: DATA_W and ADDR_W defaults (WordDataBus, SpmAddrBus), strobe constants ENABLE_=1'b0 and DISABLE_=1'b1, direction constants READ=1'b1 and WRITE=1'b0.
- One natural sub-module, spm_ram_sp: a generic synchronous single-port RAM (we, addr, wdata, rdata registered).
- spm_mem wraps spm_ram_sp with:
  - strobe/direction decode: we = ~as_ & (rw==WRITE); re = ~as_ & (rw==READ);
  - reset of the output register.

Test Plan:
- Hold rst high for a few cycles, then release -> rd_data=0 during and after reset until the first read; as_=1 with rw=X for 20 cycles causes no change.
- Sixteen consecutive write cycles, addr=i, wr_data=255-i for i=0..15, followed by 20 idle cycles and then sixteen consecutive read cycles addr=0..15 -> rd_data equals 255-i one cycle after each read is issued (255, 254, … 240), with no gaps.
- Write 0xDEADBEEF to addr 4095 and 0x12345678 to addr 0, then read both -> correct values returned; no aliasing between the ends of the array.
- Write addr 5 = 0xA5A5A5A5, read addr 5 in the very next cycle -> 0xA5A5A5A5; then issue as_=1 with rw=WRITE and wr_data=0 at addr 5, and read again -> still 0xA5A5A5A5.
- Read addr 3 (value 252) to get rd_data=252; then assert rst asynchronously mid-cycle -> rd_data goes to 0 before the next edge. Release rst and read addr 3 -> 252 (contents preserved).
- Interleave write addr 7 = 0x1, read addr 7, write addr 7 = 0x2, read addr 7 on consecutive cycles -> reads return 0x1 then 0x2, each with 1-cycle latency.

Source files
------------

// File: rtl/spm_mem_pkg.sv
// Shared widths and bus encodings for the scratchpad memory.
// Strobe and direction values are named so decode logic reads like the bus protocol.
package spm_mem_pkg;

  localparam int WORD_DATA_W = 32;  // WordDataBus
  localparam int SPM_ADDR_W  = 12;  // SpmAddrBus, 4096 words

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage

// File: rtl/spm_mem_if.sv
// CPU-side access bus of the scratchpad: address strobe, direction, data.
interface spm_mem_if
  import spm_mem_pkg::*;
#(
  parameter int DATA_W = WORD_DATA_W,
  parameter int ADDR_W = SPM_ADDR_W
);

  logic [ADDR_W-1:0] addr;
  logic              as_;
  logic              rw;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (output addr, as_, rw, wr_data, input  rd_data);
  modport slave  (input  addr, as_, rw, wr_data, output rd_data);

endinterface

// File: rtl/spm_mem_ram_sp.sv
// Generic single-port synchronous RAM with a registered read port.
// Array has no reset so it maps onto block RAM; only the output register resets.
module spm_ram_sp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Holds between reads so the CPU may sample it late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spm_mem.sv
// Scratchpad memory: decodes the active-low strobe and direction into
// write/read enables for a single-port RAM with one-cycle read latency.
module spm_mem
  import spm_mem_pkg::*;
#(
  parameter int DATA_W = WORD_DATA_W,
  parameter int ADDR_W = SPM_ADDR_W
) (
  input  logic     clk,
  input  logic     rst,
  spm_mem_if.slave if_spm
);

  logic              we;
  logic              re;
  logic [DATA_W-1:0] rd_data;

  // Strobe term first so an X on rw during idle cycles resolves to 0;
  // rst masks both so an edge under reset neither writes nor reads.
  always_comb begin
    we = 1'b0;
    re = 1'b0;
    if (!rst && (if_spm.as_ == ENABLE_)) begin
      we = (if_spm.rw == WRITE);
      re = (if_spm.rw == READ);
    end
  end

  spm_ram_sp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .addr  (if_spm.addr),
    .wdata (if_spm.wr_data),
    .rdata (rd_data)
  );

  assign if_spm.rd_data = rd_data;

endmodule

// File: tb/tb_spm_mem.sv
// Directed bench for spm_mem: reset, streaming writes/reads, array ends,
// idle immunity, asynchronous reset and read-after-write interleaving.
module tb_spm_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  spm_mem_if #(.DATA_W(32), .ADDR_W(12)) bus ();

  spm_mem dut (
    .clk    (clk),
    .rst    (rst),
    .if_spm (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Inputs change #1 after a rising edge; outputs sampled #1 after the next.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.as_     = 1'b1;
    bus.rw      = 1'bx;
    bus.addr    = 'x;
    bus.wr_data = 'x;
  endtask

  task automatic drive_wr(input logic [11:0] a, input logic [31:0] d);
    bus.as_ = 1'b0; bus.rw = 1'b0; bus.addr = a; bus.wr_data = d;
  endtask

  task automatic drive_rd(input logic [11:0] a);
    bus.as_ = 1'b0; bus.rw = 1'b1; bus.addr = a; bus.wr_data = 'x;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.rd_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold got %h want %h", bus.rd_data, 32'h0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.rd_data !== 32'h0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d got %h want %h", i, bus.rd_data, 32'h0);
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++) begin
      drive_wr(12'(i), 32'(255 - i));
      tick();
      checks++;
      if (bus.rd_data !== 32'h0) begin
        errors++;
        $display("FAIL write_holds_rd i=%0d got %h want %h", i, bus.rd_data, 32'h0);
      end
    end
    drive_idle();
    for (int i = 0; i < 20; i++) tick();
    for (int i = 0; i < 16; i++) begin
      drive_rd(12'(i));
      tick();
      checks++;
      if (bus.rd_data !== 32'(255 - i)) begin
        errors++;
        $display("FAIL stream_read addr=%0d got %0d want %0d", i, bus.rd_data, 255 - i);
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_ends();
    drive_wr(12'd4095, 32'hDEADBEEF); tick();
    drive_wr(12'd0,    32'h12345678); tick();
    drive_rd(12'd4095);               tick();
    checks++;
    if (bus.rd_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL end_4095 got %h want %h", bus.rd_data, 32'hDEADBEEF);
    end
    drive_rd(12'd0); tick();
    checks++;
    if (bus.rd_data !== 32'h12345678) begin
      errors++;
      $display("FAIL end_0 got %h want %h", bus.rd_data, 32'h12345678);
    end
    drive_rd(12'd15); tick();
    checks++;
    if (bus.rd_data !== 32'd240) begin
      errors++;
      $display("FAIL addr15_intact got %h want %h", bus.rd_data, 32'd240);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    drive_wr(12'd5, 32'hA5A5A5A5); tick();
    drive_rd(12'd5);               tick();
    checks++;
    if (bus.rd_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL raw_next_cycle got %h want %h", bus.rd_data, 32'hA5A5A5A5);
    end
    // Strobe inactive: must neither write nor disturb rd_data.
    bus.as_ = 1'b1; bus.rw = 1'b0; bus.addr = 12'd5; bus.wr_data = 32'h0;
    tick();
    checks++;
    if (bus.rd_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL unstrobed_hold got %h want %h", bus.rd_data, 32'hA5A5A5A5);
    end
    drive_rd(12'd5); tick();
    checks++;
    if (bus.rd_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL unstrobed_no_write got %h want %h", bus.rd_data, 32'hA5A5A5A5);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_async_reset();
    drive_rd(12'd3); tick();
    checks++;
    if (bus.rd_data !== 32'd252) begin
      errors++;
      $display("FAIL pre_reset_read got %0d want %0d", bus.rd_data, 252);
    end
    drive_idle();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rd_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got %h want %h", bus.rd_data, 32'h0);
    end
    // Write and read attempts under reset are ignored.
    @(posedge clk); #1;
    drive_wr(12'd3, 32'h0); tick();
    drive_rd(12'd3);        tick();
    checks++;
    if (bus.rd_data !== 32'h0) begin
      errors++;
      $display("FAIL read_in_reset got %h want %h", bus.rd_data, 32'h0);
    end
    drive_idle();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.rd_data !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_idle got %h want %h", bus.rd_data, 32'h0);
    end
    drive_rd(12'd3); tick();
    checks++;
    if (bus.rd_data !== 32'd252) begin
      errors++;
      $display("FAIL contents_kept got %0d want %0d", bus.rd_data, 252);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_interleave();
    drive_wr(12'd7, 32'h1); tick();
    drive_rd(12'd7);        tick();
    checks++;
    if (bus.rd_data !== 32'h1) begin
      errors++;
      $display("FAIL interleave_rd1 got %h want %h", bus.rd_data, 32'h1);
    end
    drive_wr(12'd7, 32'h2); tick();
    checks++;
    if (bus.rd_data !== 32'h1) begin
      errors++;
      $display("FAIL interleave_wr_hold got %h want %h", bus.rd_data, 32'h1);
    end
    drive_rd(12'd7); tick();
    checks++;
    if (bus.rd_data !== 32'h2) begin
      errors++;
      $display("FAIL interleave_rd2 got %h want %h", bus.rd_data, 32'h2);
    end
    drive_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ends();
    test_back_to_back();
    test_async_reset();
    test_interleave();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
